// File: rtl/stats_pkg.sv
// Shared types and default widths for the statistics FIFO scheduler.
// Optional build macro STATS_SAT_EN selects saturating counters (see stats_fifo_sched).
package stats_pkg;

    localparam int unsigned LEN_W_DEF = 14;
    localparam int unsigned CNT_W_DEF = 32;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_e;

    typedef enum logic {
        GNT_TX = 1'b0,
        GNT_RX = 1'b1
    } gnt_e;

endpackage

// File: rtl/stats_fifo_sched_if.sv
// Bundle of stats FIFO read ports, clear requests and counter outputs.
// master = scheduler side, slave = FIFO/register-file side.
interface stats_fifo_sched_if #(
    parameter int unsigned LEN_W = stats_pkg::LEN_W_DEF,
    parameter int unsigned CNT_W = stats_pkg::CNT_W_DEF
);
    logic [LEN_W-1:0] txsfifo_rdata;
    logic             txsfifo_rempty;
    logic             txsfifo_ren;
    logic [LEN_W-1:0] rxsfifo_rdata;
    logic             rxsfifo_rempty;
    logic             rxsfifo_ren;

    logic             clear_stats_tx_octets;
    logic             clear_stats_tx_pkts;
    logic             clear_stats_rx_octets;
    logic             clear_stats_rx_pkts;

    logic [CNT_W-1:0] stats_tx_octets;
    logic [CNT_W-1:0] stats_tx_pkts;
    logic [CNT_W-1:0] stats_rx_octets;
    logic [CNT_W-1:0] stats_rx_pkts;
    logic             stats_busy;

    modport master (
        input  txsfifo_rdata, txsfifo_rempty, rxsfifo_rdata, rxsfifo_rempty,
        input  clear_stats_tx_octets, clear_stats_tx_pkts,
        input  clear_stats_rx_octets, clear_stats_rx_pkts,
        output txsfifo_ren, rxsfifo_ren,
        output stats_tx_octets, stats_tx_pkts, stats_rx_octets, stats_rx_pkts, stats_busy
    );

    modport slave (
        output txsfifo_rdata, txsfifo_rempty, rxsfifo_rdata, rxsfifo_rempty,
        output clear_stats_tx_octets, clear_stats_tx_pkts,
        output clear_stats_rx_octets, clear_stats_rx_pkts,
        input  txsfifo_ren, rxsfifo_ren,
        input  stats_tx_octets, stats_tx_pkts, stats_rx_octets, stats_rx_pkts, stats_busy
    );

endinterface

// File: rtl/stats_rr_arb.sv
// Two-way round-robin arbiter between the TX and RX stats FIFOs.
// gnt is one-hot {rx, tx}; last_grant remembers the most recent winner.
module stats_rr_arb
    import stats_pkg::*;
(
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       req_tx,
    input  logic       req_rx,
    input  logic       advance,
    output logic [1:0] gnt,
    output gnt_e       last_grant
);

    gnt_e last_q;

    assign last_grant = last_q;

    always_comb begin
        gnt = 2'b00;
        if (advance) begin
            if (req_tx && req_rx) begin
                gnt = (last_q == GNT_RX) ? 2'b01 : 2'b10;
            end else begin
                gnt = {req_rx, req_tx};
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            last_q <= GNT_RX;
        end else if (gnt[0]) begin
            last_q <= GNT_TX;
        end else if (gnt[1]) begin
            last_q <= GNT_RX;
        end
    end

endmodule

// File: rtl/stats_fifo_sched.sv
// Drains TX/RX stats FIFOs round-robin into four counters via one shared adder pair.
// Define STATS_SAT_EN for counters that saturate at all-ones instead of wrapping.
module stats_fifo_sched
    import stats_pkg::*;
#(
    parameter int unsigned LEN_W = LEN_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    stats_fifo_sched_if.master  bus
);

    state_e           state_q, state_d;
    logic [1:0]       gnt;
    gnt_e             sel;
    logic             acc_en;

    logic [CNT_W-1:0] tx_oct_q, tx_pkt_q, rx_oct_q, rx_pkt_q;
    logic [CNT_W-1:0] tx_oct_d, tx_pkt_d, rx_oct_d, rx_pkt_d;
    logic [CNT_W-1:0] tx_oct_base, tx_pkt_base, rx_oct_base, rx_pkt_base;
    logic [CNT_W-1:0] oct_a, pkt_a, oct_res, pkt_res;
    logic [LEN_W-1:0] rdata_sel;

    // Reset holds advance low so no pop is issued in the reset cycle.
    stats_rr_arb u_arb (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .req_tx     (~bus.txsfifo_rempty),
        .req_rx     (~bus.rxsfifo_rempty),
        .advance    (~wb_rst_i),
        .gnt        (gnt),
        .last_grant (sel)
    );

    assign bus.txsfifo_ren = gnt[0];
    assign bus.rxsfifo_ren = gnt[1];
    assign bus.stats_busy  = (state_q == ACC);
    assign acc_en          = (state_q == ACC);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (|gnt) state_d = ACC;
            ACC:     state_d = (|gnt) ? ACC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Clears are folded in ahead of the adder so clear+accumulate yields 0 + increment.
    always_comb begin
        tx_oct_base = bus.clear_stats_tx_octets ? '0 : tx_oct_q;
        tx_pkt_base = bus.clear_stats_tx_pkts   ? '0 : tx_pkt_q;
        rx_oct_base = bus.clear_stats_rx_octets ? '0 : rx_oct_q;
        rx_pkt_base = bus.clear_stats_rx_pkts   ? '0 : rx_pkt_q;
        oct_a       = (sel == GNT_TX) ? tx_oct_base : rx_oct_base;
        pkt_a       = (sel == GNT_TX) ? tx_pkt_base : rx_pkt_base;
        rdata_sel   = (sel == GNT_TX) ? bus.txsfifo_rdata : bus.rxsfifo_rdata;
    end

`ifdef STATS_SAT_EN
    logic [CNT_W:0] oct_sum, pkt_sum;

    always_comb begin
        oct_sum = {1'b0, oct_a} + (CNT_W+1)'(rdata_sel);
        pkt_sum = {1'b0, pkt_a} + (CNT_W+1)'(1);
        oct_res = oct_sum[CNT_W] ? '1 : oct_sum[CNT_W-1:0];
        pkt_res = pkt_sum[CNT_W] ? '1 : pkt_sum[CNT_W-1:0];
    end
`else
    always_comb begin
        oct_res = oct_a + CNT_W'(rdata_sel);
        pkt_res = pkt_a + CNT_W'(1);
    end
`endif

    always_comb begin
        tx_oct_d = tx_oct_base;
        tx_pkt_d = tx_pkt_base;
        rx_oct_d = rx_oct_base;
        rx_pkt_d = rx_pkt_base;
        if (acc_en && sel == GNT_TX) begin
            tx_oct_d = oct_res;
            tx_pkt_d = pkt_res;
        end
        if (acc_en && sel == GNT_RX) begin
            rx_oct_d = oct_res;
            rx_pkt_d = pkt_res;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= IDLE;
            tx_oct_q <= '0;
            tx_pkt_q <= '0;
            rx_oct_q <= '0;
            rx_pkt_q <= '0;
        end else begin
            state_q  <= state_d;
            tx_oct_q <= tx_oct_d;
            tx_pkt_q <= tx_pkt_d;
            rx_oct_q <= rx_oct_d;
            rx_pkt_q <= rx_pkt_d;
        end
    end

    assign bus.stats_tx_octets = tx_oct_q;
    assign bus.stats_tx_pkts   = tx_pkt_q;
    assign bus.stats_rx_octets = rx_oct_q;
    assign bus.stats_rx_pkts   = rx_pkt_q;

endmodule
